// File: rtl/fetch_stage_pkg.sv
// Shared constants and fetch FSM encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_INC      = 4;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats freeze, freeze beats load, otherwise a bubble is inserted.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               load,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (freeze) begin
      pc    <= pc;
      instr <= instr;
      valid <= valid;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end else begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, hold buffer for frozen responses and redirect handling
// over a req/ready instruction memory; feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               fetch_stall
);

  // Handshake: imem_req stays high with imem_addr stable until a cycle with
  // imem_ready=1, which retires the request and carries valid imem_rdata.
  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  tgt;
  logic [ADDR_W-1:0]  hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               req_q;
  logic               rdy;
  logic [ADDR_W-1:0]  pc_plus;
  logic               load;
  logic [ADDR_W-1:0]  load_pc;
  logic [INSTR_W-1:0] load_instr;

  assign rdy     = imem_ready & req_q;
  assign pc_plus = pc + ADDR_W'(PC_INC);

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign fetch_stall = (state == FETCH) & req_q & ~imem_ready & ~freeze & ~branch_taken;

  always_comb begin
    load       = 1'b0;
    load_pc    = pc_plus;
    load_instr = imem_rdata;
    if (state == HOLD) begin
      load       = 1'b1;
      load_pc    = hold_pc;
      load_instr = hold_instr;
    end else if (state == FETCH) begin
      load = rdy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      tgt        <= '0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
      req_q      <= 1'b0;
    end else begin
      req_q <= 1'b1;
      if (branch_taken) begin
        hold_pc    <= '0;
        hold_instr <= NOP_INSTR;
      end
      case (state)
        FETCH: begin
          if (branch_taken) begin
            // With nothing outstanding the redirect can take effect at once.
            if (rdy || !req_q) begin
              pc <= branch_address;
            end else begin
              tgt   <= branch_address;
              state <= DISCARD;
            end
          end else if (rdy) begin
            pc <= pc_plus;
            if (freeze) begin
              hold_pc    <= pc_plus;
              hold_instr <= imem_rdata;
              state      <= HOLD;
              req_q      <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc    <= branch_address;
            state <= FETCH;
          end else if (!freeze) begin
            state <= FETCH;
          end else begin
            req_q <= 1'b0;
          end
        end
        DISCARD: begin
          // A redirect landing on the retiring cycle needs no further discard.
          if (branch_taken && rdy) begin
            pc    <= branch_address;
            state <= FETCH;
          end else if (branch_taken) begin
            tgt <= branch_address;
          end else if (rdy) begin
            pc    <= tgt;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  fetch_stage_if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .flush   (branch_taken),
    .freeze  (freeze),
    .load    (load),
    .pc_in   (load_pc),
    .instr_in(load_instr),
    .pc      (if_id_pc),
    .instr   (if_id_instr),
    .valid   (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a memory responder and an in-order program scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0;
  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] SALT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_stall;

  fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (RPC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_address(branch_address),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_stall   (fetch_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n_consumed = 0;

  // scoreboard: program-order address of the next instruction ID should consume
  logic [31:0] exp_q[$];

  // memory responder state
  bit          rand_lat = 1'b0;
  int          lat_cfg = 0;
  bit          in_flight = 1'b0;
  int          age = 0;
  int          cur_lat = 0;
  logic [31:0] req_addr = '0;
  logic        stall_obs;

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && imem_ready) begin
      n_assert++;
      assert (imem_req === 1'b1) else begin
        n_fail++;
        $error("FAIL ready_without_req observed=%b expected=1", imem_req);
      end
    end
  end

  task automatic sb_reset();
    exp_q.delete();
    exp_q.push_back(RPC);
    in_flight = 1'b0;
    imem_ready = 1'b0;
  endtask

  // driver: one clock cycle of stimulus, responder and scoreboard
  task automatic cycle(input logic frz, input logic br, input logic [31:0] tgt);
    logic [31:0] e;
    freeze = frz;
    branch_taken = br;
    branch_address = tgt;
    if (imem_req) begin
      if (!in_flight) begin
        in_flight = 1'b1;
        age = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
        req_addr = imem_addr;
      end else begin
        check("addr_stable", imem_addr, req_addr);
      end
      imem_ready = (age >= cur_lat);
      imem_rdata = imem_ready ? model_instr(imem_addr) : $urandom;
    end else begin
      in_flight = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    stall_obs = fetch_stall;
    if (!if_id_valid) check("bubble_nop", if_id_instr, NOP);
    if (if_id_valid && !frz && !br) begin
      e = exp_q.pop_front();
      check("sb_pc", if_id_pc, e + 32'd4);
      check("sb_instr", if_id_instr, model_instr(e));
      exp_q.push_back(e + 32'd4);
      n_consumed++;
    end
    if (br) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
    @(posedge clk);
    #1;
    if (imem_ready) in_flight = 1'b0;
    else if (in_flight) age++;
    imem_ready = 1'b0;
  endtask

  initial begin
    int c0;
    // reset state
    sb_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", if_id_valid, 0);
    check("rst_pc", if_id_pc, 0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_addr", imem_addr, RPC);
    rst = 1'b0;
    #1;
    check("req_after_release", imem_req, 0);

    // single-cycle memory, back-to-back
    lat_cfg = 0;
    cycle(0, 0, 0);
    check("first_req", imem_req, 1);
    check("first_valid", if_id_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0);
      check("b2b_valid", if_id_valid, 1);
      check("b2b_pc", if_id_pc, 32'(4 * i));
      check("b2b_addr", imem_addr, 32'(4 * i));
    end

    // freeze for 3 cycles, response lands in the first
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      check("frz_pc", if_id_pc, 32'h10);
      check("frz_instr", if_id_instr, model_instr(32'h0C));
      check("frz_valid", if_id_valid, 1);
      check("frz_req", imem_req, 0);
    end
    cycle(0, 0, 0);
    check("unfrz_pc", if_id_pc, 32'h14);
    check("unfrz_instr", if_id_instr, model_instr(32'h10));
    check("unfrz_req", imem_req, 1);
    check("unfrz_addr", imem_addr, 32'h14);

    // 3-cycle memory latency
    lat_cfg = 2;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        cycle(0, 0, 0);
        check("lat_stall", stall_obs, (j < 2) ? 1 : 0);
        if (j < 2) begin
          check("lat_bubble_valid", if_id_valid, 0);
        end else begin
          check("lat_valid", if_id_valid, 1);
          check("lat_pc", if_id_pc, 32'h18 + 32'(4 * k));
        end
      end
    end

    // redirect with a response outstanding
    lat_cfg = 1;
    cycle(0, 1, 32'h100);
    check("br_flush_valid", if_id_valid, 0);
    check("br_flush_instr", if_id_instr, NOP);
    check("br_stale_addr", imem_addr, 32'h1C);
    check("br_stale_req", imem_req, 1);
    cycle(0, 0, 0);
    check("br_new_addr", imem_addr, 32'h100);
    check("br_drop_valid", if_id_valid, 0);
    cycle(0, 0, 0);
    check("br_wait_valid", if_id_valid, 0);
    cycle(0, 0, 0);
    check("br_first_pc", if_id_pc, 32'h104);
    check("br_first_instr", if_id_instr, model_instr(32'h100));

    // branch and freeze together
    lat_cfg = 0;
    cycle(1, 1, 32'h200);
    check("bf_valid", if_id_valid, 0);
    check("bf_addr", imem_addr, 32'h200);
    cycle(1, 0, 0);
    check("bf_hold_valid", if_id_valid, 0);
    check("bf_hold_req", imem_req, 0);
    cycle(1, 0, 0);
    check("bf_hold2_valid", if_id_valid, 0);
    cycle(0, 0, 0);
    check("bf_release_pc", if_id_pc, 32'h204);
    check("bf_release_valid", if_id_valid, 1);

    // PC wrap
    cycle(0, 1, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    check("wrap_pc", if_id_pc, 32'h0);
    check("wrap_instr", if_id_instr, model_instr(32'hFFFF_FFFC));
    check("wrap_next_addr", imem_addr, 32'h0);

    // randomized traffic
    rand_lat = 1'b1;
    c0 = n_consumed;
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 19) == 0),
            $urandom & 32'hFFFF_FFFC);
    end
    check("rand_progress", 32'(n_consumed - c0 >= 40), 1);

    // reset in the middle of an outstanding request
    rand_lat = 1'b0;
    lat_cfg = 3;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_valid", if_id_valid, 0);
    check("mid_rst_addr", imem_addr, RPC);
    check("mid_rst_instr", if_id_instr, NOP);
    sb_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rand_lat = 1'b1;
    c0 = n_consumed;
    for (int i = 0; i < 80; i++) begin
      cycle(logic'($urandom_range(0, 9) < 2), 1'b0, 0);
    end
    check("post_rst_progress", 32'(n_consumed - c0 >= 8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
